// File: rtl/note_input_capture.sv
// rtl/note_input_capture.sv - debounced single-key note capture with held-key echo and multi-press flag
// Optional idle timeout strobe: define NOTE_TIMEOUT_EN.
module note_input_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] key_n,
    output logic       note_valid,
    output logic [3:0] note_code,
    output logic [3:0] note_echo,
    output logic       multi_press,
`ifdef NOTE_TIMEOUT_EN
    output logic       timeout,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       pressed;
    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [3:0]       cand;
    logic [3:0]       nxt_cand;
    logic             fire_note;
    logic             fire_multi;
    logic             cand_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed     = ~sync2;
    assign cand_onehot = (cand != 4'b0000) && ((cand & (cand - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 4'b0000;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            cand  <= nxt_cand;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_cand   = cand;
        fire_note  = 1'b0;
        fire_multi = 1'b0;
        case (state)
            IDLE: begin
                if (pressed != 4'b0000) begin
                    nxt_cnt = '0;
                    if (enable) begin
                        nxt_cand  = pressed;
                        nxt_state = PRESS_WAIT;
                    end else begin
                        // Swallow presses outside the response phase until a full release
                        nxt_cand  = 4'b0000;
                        nxt_state = HELD;
                    end
                end
            end
            PRESS_WAIT: begin
                if ((pressed != cand) || !enable) begin
                    nxt_cnt   = '0;
                    nxt_state = IDLE;
                end else if (cnt == DB_LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = HELD;
                    if (cand_onehot) begin
                        fire_note = 1'b1;
                    end else begin
                        fire_multi = 1'b1;
                        nxt_cand   = 4'b0000;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (pressed == 4'b0000) begin
                    nxt_cnt   = '0;
                    nxt_state = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (pressed != 4'b0000) begin
                    nxt_cnt   = '0;
                    nxt_state = HELD;
                end else if (cnt == DB_LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = IDLE;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            default: begin
                nxt_cnt   = '0;
                nxt_cand  = 4'b0000;
                nxt_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they align with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_valid  <= 1'b0;
            multi_press <= 1'b0;
            note_code   <= 4'b0000;
            note_echo   <= 4'b0000;
            busy        <= 1'b0;
        end else begin
            note_valid  <= fire_note;
            multi_press <= fire_multi;
            if (fire_note) begin
                note_code <= cand;
            end
            note_echo <= (nxt_state == HELD) ? nxt_cand : 4'b0000;
            busy      <= (nxt_state != IDLE);
        end
    end

`ifdef NOTE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (enable && (state == IDLE) && (pressed == 4'b0000)) begin
                if (idle_cnt == TO_LAST) begin
                    idle_cnt <= '0;
                    timeout  <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + CNT_ONE;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_note_input_capture.sv
// tb/tb_note_input_capture.sv - directed self-checking bench for note_input_capture
module tb_note_input_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] key_n;
    logic       note_valid;
    logic [3:0] note_code;
    logic [3:0] note_echo;
    logic       multi_press;
    logic       busy;
`ifdef NOTE_TIMEOUT_EN
    logic       timeout;
`endif

    int errors = 0;
    int checks = 0;

    note_input_capture #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .key_n(key_n),
        .note_valid(note_valid),
        .note_code(note_code),
        .note_echo(note_echo),
        .multi_press(multi_press),
`ifdef NOTE_TIMEOUT_EN
        .timeout(timeout),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_keys();
        int n;
        key_n = 4'b1111;
        n = 0;
        tick();
        while (busy && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        key_n  = 4'b1111;
        repeat (3) tick();
        checks++;
        if ({note_valid, note_code, note_echo, multi_press, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {note_valid, note_code, note_echo, multi_press, busy});
        end
        reset = 1'b0;
        tick();
    endtask

`ifdef NOTE_TIMEOUT_EN
    task automatic test_timeout();
        int first;
        int second;
        int cnt;
        first = 0; second = 0; cnt = 0;
        enable = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (timeout) begin
                cnt++;
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        checks++;
        if (first !== 20 || second !== 40 || cnt !== 2) begin
            errors++;
            $display("FAIL timeout_period: first=%0d second=%0d count=%0d required 20 40 2", first, second, cnt);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 10) key_n = 4'b1110;
            tick();
            if (timeout) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL timeout_suppressed: count=%0d required 0", cnt);
        end
        release_keys();
        enable = 1'b0;
    endtask
`endif

    task automatic test_clean_press();
        int vcnt;
        int vat;
        int mcnt;
        vcnt = 0; vat = 0; mcnt = 0;
        enable = 1'b1;
        key_n  = 4'b1101;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (note_valid) begin
                vcnt++;
                vat = k;
            end
            if (multi_press) mcnt++;
        end
        checks++;
        if (vcnt !== 1 || vat !== 7) begin
            errors++;
            $display("FAIL clean_latency: pulses=%0d at edge %0d required 1 at 7", vcnt, vat);
        end
        checks++;
        if (mcnt !== 0) begin
            errors++;
            $display("FAIL clean_multi: multi pulses=%0d required 0", mcnt);
        end
        checks++;
        if (note_code !== 4'b0010 || note_echo !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_held: code=%b echo=%b busy=%b required 0010 0010 1", note_code, note_echo, busy);
        end
        key_n = 4'b1111;
        repeat (3) tick();
        checks++;
        if (note_echo !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_release_echo: echo=%b busy=%b required 0000 1", note_echo, busy);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_release_early: busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || note_code !== 4'b0010) begin
            errors++;
            $display("FAIL clean_release_done: busy=%b code=%b required 0 0010", busy, note_code);
        end
    endtask

    task automatic test_bounce();
        int vcnt;
        vcnt = 0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_n = 4'b1110;
            repeat (2) begin tick(); if (note_valid) vcnt++; end
            key_n = 4'b1111;
            repeat (2) begin tick(); if (note_valid) vcnt++; end
        end
        key_n = 4'b1110;
        repeat (12) begin tick(); if (note_valid) vcnt++; end
        checks++;
        if (vcnt !== 1 || note_code !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_press: pulses=%0d code=%b required 1 0001", vcnt, note_code);
        end
        release_keys();
    endtask

    task automatic test_multi_key();
        int vcnt;
        int mcnt;
        vcnt = 0; mcnt = 0;
        enable = 1'b1;
        key_n  = 4'b1010;
        repeat (10) begin
            tick();
            if (note_valid) vcnt++;
            if (multi_press) mcnt++;
        end
        checks++;
        if (mcnt !== 1 || vcnt !== 0) begin
            errors++;
            $display("FAIL multi_strobe: multi=%0d valid=%0d required 1 0", mcnt, vcnt);
        end
        checks++;
        if (note_code !== 4'b0001 || note_echo !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL multi_state: code=%b echo=%b busy=%b required 0001 0000 1", note_code, note_echo, busy);
        end
        release_keys();
    endtask

    task automatic test_enable_gating();
        int scnt;
        scnt = 0;
        enable = 1'b0;
        key_n  = 4'b0111;
        repeat (6) begin tick(); if (note_valid || multi_press) scnt++; end
        enable = 1'b1;
        repeat (10) begin tick(); if (note_valid || multi_press) scnt++; end
        checks++;
        if (scnt !== 0 || note_echo !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gate_swallow: strobes=%0d echo=%b busy=%b required 0 0000 1", scnt, note_echo, busy);
        end
        release_keys();
        scnt = 0;
        key_n = 4'b0111;
        repeat (10) begin tick(); if (note_valid) scnt++; end
        checks++;
        if (scnt !== 1 || note_code !== 4'b1000 || note_echo !== 4'b1000) begin
            errors++;
            $display("FAIL gate_fresh: pulses=%0d code=%b echo=%b required 1 1000 1000", scnt, note_code, note_echo);
        end
        release_keys();
    endtask

    task automatic test_reset_mid_press();
        int vat;
        vat = 0;
        enable = 1'b1;
        key_n  = 4'b1011;
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({note_valid, note_code, note_echo, multi_press, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got %b required 0", {note_valid, note_code, note_echo, multi_press, busy});
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (note_valid && vat == 0) vat = k;
        end
        checks++;
        if (vat !== 7 || note_code !== 4'b0100) begin
            errors++;
            $display("FAIL reset_recover: valid at edge %0d code=%b required 7 0100", vat, note_code);
        end
        release_keys();
    endtask

    initial begin
        test_reset();
`ifdef NOTE_TIMEOUT_EN
        test_timeout();
`endif
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_enable_gating();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
